// File: rtl/avalon_burst_arbiter.sv
// avalon_burst_arbiter: two-master round-robin Avalon-MM arbiter with whole-burst grant locking
module avalon_burst_arbiter #(
  parameter int BURST_W = 5,
  parameter int ADDR_W = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [ADDR_W-1:0]  m0_address,
  input  logic               m0_read,
  input  logic               m0_write,
  input  logic [31:0]        m0_writedata,
  input  logic [BURST_W-1:0] m0_burstcount,
  output logic               m0_waitrequest,
  output logic [31:0]        m0_readdata,
  output logic               m0_readdatavalid,
  input  logic [ADDR_W-1:0]  m1_address,
  input  logic               m1_read,
  input  logic               m1_write,
  input  logic [31:0]        m1_writedata,
  input  logic [BURST_W-1:0] m1_burstcount,
  output logic               m1_waitrequest,
  output logic [31:0]        m1_readdata,
  output logic               m1_readdatavalid,
  output logic [ADDR_W-1:0]  av_address,
  output logic               av_read,
  output logic               av_write,
  output logic [31:0]        av_writedata,
  output logic [BURST_W-1:0] av_burstcount,
  input  logic               av_waitrequest,
  input  logic [31:0]        av_readdata,
  input  logic               av_readdatavalid
);
  typedef enum logic [1:0] {IDLE, RD_CMD, RD_DATA, WR_BURST} state_t;
  state_t state, state_nx;
  logic owner, last_grant;
  logic [BURST_W-1:0] beats_left;
  logic req0, req1, req, winner, win_rd, rd_phase, cmd_phase, beat, done, own_write;
  logic [BURST_W-1:0] win_bc, own_bc;
  logic [ADDR_W-1:0] own_addr;
  logic [31:0] own_wd;
  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;
  assign req = req0 | req1;
  assign winner = req0 && req1 ? ~last_grant : req1;
  assign win_rd = winner ? m1_read : m0_read;
  assign win_bc = winner ? m1_burstcount : m0_burstcount;
  assign own_addr = owner ? m1_address : m0_address;
  assign own_bc = owner ? m1_burstcount : m0_burstcount;
  assign own_wd = owner ? m1_writedata : m0_writedata;
  assign own_write = owner ? m1_write : m0_write;
  assign rd_phase = state == RD_CMD || state == RD_DATA;
  assign cmd_phase = state == RD_CMD || state == WR_BURST;
  assign beat = rd_phase ? av_readdatavalid : state == WR_BURST && own_write && !av_waitrequest;
  assign done = beat && beats_left == BURST_W'(1) && (state != RD_CMD || !av_waitrequest);
  assign av_read = state == RD_CMD;
  assign av_write = state == WR_BURST && own_write;
  assign av_address = state != IDLE ? own_addr : '0;
  assign av_burstcount = state != IDLE ? own_bc : '0;
  assign av_writedata = state == WR_BURST ? own_wd : '0;
  assign m0_waitrequest = !(cmd_phase && !owner) || av_waitrequest;
  assign m1_waitrequest = !(cmd_phase && owner) || av_waitrequest;
  assign m0_readdatavalid = rd_phase && !owner && av_readdatavalid;
  assign m1_readdatavalid = rd_phase && owner && av_readdatavalid;
  assign m0_readdata = rd_phase && !owner ? av_readdata : '0;
  assign m1_readdata = rd_phase && owner ? av_readdata : '0;
  always_comb begin
    state_nx = state;
    if (state == IDLE) begin
      if (req) state_nx = win_rd ? RD_CMD : WR_BURST;
    end else if (done) begin
      state_nx = IDLE;
    end else if (state == RD_CMD && !av_waitrequest) begin
      state_nx = RD_DATA;
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      owner <= 1'b0;
      last_grant <= 1'b1;
      beats_left <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req) begin
        owner <= winner;
        beats_left <= win_bc == '0 ? BURST_W'(1) : win_bc;
      end else if (beat) begin
        beats_left <= beats_left - BURST_W'(1);
      end
      if (done) last_grant <= owner;
    end
  end
endmodule
